// File: rtl/updown_counter_mod.sv
// updown_counter_mod: modulo-N up/down counter with clear, load, wrap/saturate and cascade flags
module updown_counter_mod #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             dir,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             at_limit
);
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
    localparam logic             SAT = (SATURATE != 0);
    logic [WIDTH-1:0] q_nxt;
    logic             wrap_nxt;
    // limit/terminal-count flags; tc is the carry/borrow enable for a following stage
    always_comb begin
        at_limit = dir ? (q == '0) : (q == MAX);
        tc       = en & at_limit & ~clear & ~load;
        wrap_nxt = tc & ~SAT;
        q_nxt    = clear ? '0 :
                   load  ? ((load_val > MAX) ? MAX : load_val) :
                   !en   ? q :
                   at_limit ? (SAT ? q : (dir ? MAX : '0)) :
                   dir   ? q - WIDTH'(1) : q + WIDTH'(1);
    end
    // state updates on the falling edge; reset clears immediately
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            q    <= '0;
            wrap <= 1'b0;
        end else begin
            q    <= q_nxt;
            wrap <= wrap_nxt;
        end
    end
endmodule
